acumulador_suma: RTL and testbench
==================================

ACUMULADOR_SUMA -- requirements
Module: acumulador_suma

Interface
REQ-001 Parameter N_MUESTRAS, default 4, number of adder results summed per block (legal range 2..255).
REQ-002 Parameter ACC_W, default 8, accumulator and result width in bits (legal range 5..16).
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port clr, input, 1, synchronous clear of the block in progress.
REQ-006 Port s, input, 4, sum bits from the upstream 4-bit adder.
REQ-007 Port cout, input, 1, carry bit from the upstream 4-bit adder.
REQ-008 Port in_valid, input, 1, s/cout carry a valid sample this cycle.
REQ-009 Port in_ready, output, 1, block accepts a sample this cycle.
REQ-010 Port suma, output, ACC_W, accumulated block result.
REQ-011 Port ovf, output, 1, the block's true sum exceeded 2^ACC_W-1.
REQ-012 Port cnt, output, 8, samples accepted in the current block.
REQ-013 Port out_valid, output, 1, suma/ovf hold a completed block result.
REQ-014 Port out_ready, input, 1, downstream consumes the result this cycle.

Function
REQ-015 Sample value SHALL be {cout,s}, an unsigned 5-bit value 0..31, zero-extended to ACC_W.
REQ-016 The FSM SHALL have two states: ACUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-017 A sample SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-018 On acceptance in ACUM: acc <= (acc+value) mod 2^ACC_W, and cnt <= cnt+1.
REQ-019 On acceptance, ovf SHALL be set if acc+value >= 2^ACC_W; ovf is sticky until the block is cleared.
REQ-020 An acceptance with cnt==N_MUESTRAS-1 SHALL move the FSM to DONE on that edge, with the final sum and ovf registered.
REQ-021 out_valid SHALL be asserted in the cycle after the final acceptance (latency 1 clock).
REQ-022 In DONE, suma, ovf and cnt SHALL hold stable; in_valid is ignored.
REQ-023 In DONE, when out_ready=1 on a rising edge, acc, ovf and cnt SHALL clear to 0 and the FSM SHALL return to ACUM.
REQ-024 An in_valid asserted in the same cycle as that handshake SHALL NOT be accepted, because in_ready=0 in that cycle.
REQ-025 out_valid, once asserted, SHALL NOT deassert without out_ready=1.
REQ-026 clr=1 SHALL take priority over all other inputs: acc, ovf and cnt go to 0, the FSM goes to ACUM, and any sample or result presented in that cycle is discarded.
REQ-027 suma SHALL always show acc, so that the partial sum is visible in ACUM.
REQ-028 Outputs SHALL be driven only by registers and the FSM state, with no combinational path from an input to an output.

Reset
REQ-029 While rst_n=0, asynchronously: FSM=ACUM, acc=0, suma=0, ovf=0, cnt=0, out_valid=0, in_ready=1.
REQ-030 Reset asserted mid-block or in DONE SHALL discard all partial and pending results.
REQ-031 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-032 N_MUESTRAS=4, ACC_W=8, samples (s,cout) = (0000,0),(0010,0),(0100,0),(0010,1) with in_valid held high -> one cycle after the 4th edge: out_valid=1, suma=24, ovf=0, cnt=4.
REQ-033 Same run with out_ready=0 for 5 cycles and in_valid=1 throughout -> suma=24 held stable, in_ready=0, cnt stays 4; on out_ready=1 -> next cycle out_valid=0, suma=0, cnt=0.
REQ-034 N_MUESTRAS=16, ACC_W=8, sixteen samples of 31 -> suma=240 (496 mod 256), ovf=1; ovf clears after the result handshake.
REQ-035 in_valid toggling 1,0,1,0 with values 5,9,3,1 -> exactly 4 acceptances, suma=18; the low cycles add nothing.
REQ-036 After 2 samples (7,11), clr=1 together with in_valid=1 (value 4) -> next cycle: suma=0, cnt=0, ovf=0, FSM in ACUM.
REQ-037 rst_n pulsed low asynchronously in DONE -> out_valid=0 and suma=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/acumulador_suma.sv
// Block accumulator for the 5-bit {cout,s} results of a 4-bit adder: sums
// N_MUESTRAS samples, then holds the result until downstream takes it.
module acumulador_suma #(
  parameter int N_MUESTRAS = 4,
  parameter int ACC_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [3:0]       s,
  input  logic             cout,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] suma,
  output logic             ovf,
  output logic [7:0]       cnt,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACUM, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_MUESTRAS - 1);

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc, acc_nx;
  logic               ovf_r, ovf_nx;
  logic [7:0]         cnt_r, cnt_nx;
  logic [ACC_W-1:0]   value;
  logic [ACC_W:0]     sum_ext;

  // The extra top bit of sum_ext is the carry that marks a wrapped block sum.
  assign value   = ACC_W'({cout, s});
  assign sum_ext = {1'b0, acc} + {1'b0, value};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACUM;
      acc   <= '0;
      ovf_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      ovf_r <= ovf_nx;
      cnt_r <= cnt_nx;
    end
  end

  // clr overrides everything; otherwise accept in ACUM, hand off in DONE.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf_r;
    cnt_nx   = cnt_r;
    if (clr) begin
      state_nx = ACUM;
      acc_nx   = '0;
      ovf_nx   = 1'b0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ACUM: begin
          if (in_valid) begin
            acc_nx = sum_ext[ACC_W-1:0];
            ovf_nx = ovf_r | sum_ext[ACC_W];
            cnt_nx = cnt_r + 8'd1;
            if (cnt_r == LAST_IDX) state_nx = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = ACUM;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            cnt_nx   = '0;
          end
        end
        default: state_nx = ACUM;
      endcase
    end
  end

  assign in_ready  = (state == ACUM);
  assign out_valid = (state == DONE);
  assign suma      = acc;
  assign ovf       = ovf_r;
  assign cnt       = cnt_r;

endmodule

// File: tb/tb_acumulador_suma.sv
// Bench for acumulador_suma: two instances (4 and 16 samples per block) share
// stimulus and are compared every cycle against a true-sum reference model.
module tb_acumulador_suma;

  localparam int W  = 8;
  localparam int N0 = 4;
  localparam int N1 = 16;
  localparam int MAXV = (1 << W) - 1;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] s;
  logic       cout;
  logic       in_valid;
  logic       out_ready;

  logic         in_ready0, ovf0, out_valid0;
  logic [W-1:0] suma0;
  logic [7:0]   cnt0;
  logic         in_ready1, ovf1, out_valid1;
  logic [W-1:0] suma1;
  logic [7:0]   cnt1;

  int checks = 0;
  int errors = 0;

  int curVal;
  int mtot [2];
  int mcnt [2];
  bit mdone[2];

  acumulador_suma #(.N_MUESTRAS(N0), .ACC_W(W)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(s), .cout(cout),
    .in_valid(in_valid), .in_ready(in_ready0), .suma(suma0), .ovf(ovf0),
    .cnt(cnt0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  acumulador_suma #(.N_MUESTRAS(N1), .ACC_W(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(s), .cout(cout),
    .in_valid(in_valid), .in_ready(in_ready1), .suma(suma1), .ovf(ovf1),
    .cnt(cnt1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit iv, input int v, input bit c, input bit ordy);
    in_valid  = iv;
    curVal    = v;
    s         = 4'(v);
    cout      = v[4];
    clr       = c;
    out_ready = ordy;
  endtask

  function automatic int nOf(input int i);
    return (i == 0) ? N0 : N1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mtot[i]  = 0;
      mcnt[i]  = 0;
      mdone[i] = 1'b0;
    end
  endtask

  // Reference: true (unbounded) block sum; suma is its residue, ovf its excess.
  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      if (clr || (mdone[i] && out_ready)) begin
        mtot[i]  = 0;
        mcnt[i]  = 0;
        mdone[i] = 1'b0;
      end else if (!mdone[i] && in_valid) begin
        mtot[i] += curVal;
        mcnt[i] += 1;
        if (mcnt[i] == nOf(i)) mdone[i] = 1'b1;
      end
    end
  endtask

  task automatic checkAll(input string ph);
    checkOutput($sformatf("%s.n4.suma", ph), suma0, mtot[0] % (MAXV + 1));
    checkOutput($sformatf("%s.n4.ovf", ph), ovf0, (mtot[0] > MAXV));
    checkOutput($sformatf("%s.n4.cnt", ph), cnt0, mcnt[0]);
    checkOutput($sformatf("%s.n4.out_valid", ph), out_valid0, mdone[0]);
    checkOutput($sformatf("%s.n4.in_ready", ph), in_ready0, !mdone[0]);
    checkOutput($sformatf("%s.n16.suma", ph), suma1, mtot[1] % (MAXV + 1));
    checkOutput($sformatf("%s.n16.ovf", ph), ovf1, (mtot[1] > MAXV));
    checkOutput($sformatf("%s.n16.cnt", ph), cnt1, mcnt[1]);
    checkOutput($sformatf("%s.n16.out_valid", ph), out_valid1, mdone[1]);
    checkOutput($sformatf("%s.n16.in_ready", ph), in_ready1, !mdone[1]);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(ph);
  endtask

  initial begin
    int seq32[4];
    int seq35[4];
    seq32 = '{0, 2, 4, 18};
    seq35 = '{5, 9, 3, 1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    modelReset();
    #1;
    checkAll("reset");
    checkOutput("reset.in_ready", in_ready0, 1);
    #1 rst_n = 1'b1;

    // Four samples back to back, giving 24.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, seq32[k], 1'b0, 1'b0);
      step("blk4");
    end
    checkOutput("blk4.out_valid", out_valid0, 1);
    checkOutput("blk4.suma", suma0, 24);
    checkOutput("blk4.ovf", ovf0, 0);
    checkOutput("blk4.cnt", cnt0, 4);

    // Result held while downstream stalls; extra samples ignored.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 17, 1'b0, 1'b0);
      step("hold");
      checkOutput("hold.suma", suma0, 24);
      checkOutput("hold.in_ready", in_ready0, 0);
      checkOutput("hold.cnt", cnt0, 4);
    end
    applyStimulus(1'b1, 9, 1'b0, 1'b1);
    step("handshake");
    checkOutput("handshake.out_valid", out_valid0, 0);
    checkOutput("handshake.suma", suma0, 0);
    checkOutput("handshake.cnt", cnt0, 0);

    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    step("clr_sync");

    // Sixteen maximal samples wrap the 8-bit sum.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 31, 1'b0, 1'b0);
      step("ovf16");
    end
    checkOutput("ovf16.suma", suma1, 240);
    checkOutput("ovf16.ovf", ovf1, 1);
    checkOutput("ovf16.out_valid", out_valid1, 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    step("ovf16_hs");
    checkOutput("ovf16_hs.ovf", ovf1, 0);

    // Gaps between valid samples contribute nothing.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, seq35[k], 1'b0, 1'b0);
      step("gap_v");
      if (k < 3) begin
        applyStimulus(1'b0, 30, 1'b0, 1'b0);
        step("gap_i");
      end
    end
    checkOutput("gap.suma", suma0, 18);
    checkOutput("gap.out_valid", out_valid0, 1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    step("clr_sync2");

    // clr in the same cycle as a valid sample discards it.
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    step("clr_pre");
    applyStimulus(1'b1, 11, 1'b0, 1'b0);
    step("clr_pre");
    applyStimulus(1'b1, 4, 1'b1, 1'b0);
    step("clr");
    checkOutput("clr.suma", suma0, 0);
    checkOutput("clr.cnt", cnt0, 0);
    checkOutput("clr.ovf", ovf0, 0);
    checkOutput("clr.in_ready", in_ready0, 1);

    // Asynchronous reset while a result is pending.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 20 + k, 1'b0, 1'b0);
      step("pre_rst");
    end
    checkOutput("pre_rst.out_valid", out_valid0, 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst.out_valid", out_valid0, 0);
    checkOutput("arst.suma", suma0, 0);
    modelReset();
    checkAll("arst");
    #1 rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
